// File: rtl/branch_resolve_unit.sv
// Multi-lane registered branch resolution stage.
// Resolves up to CHANNELS branch-class ops per cycle, raises a single prioritised
// fetch redirect, and buffers predictor training records in a small FIFO.
module branch_resolve_unit #(
    parameter int CHANNELS  = 2,
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [32*CHANNELS-1:0]   in_pc,
    input  logic [32*CHANNELS-1:0]   in_inst,
    input  logic [8*CHANNELS-1:0]    in_aluop,
    input  logic [32*CHANNELS-1:0]   in_reg1,
    input  logic [32*CHANNELS-1:0]   in_reg2,
    input  logic [CHANNELS-1:0]      in_pre_taken,
    input  logic [32*CHANNELS-1:0]   in_pre_addr,
    input  logic                     ext_flush,
    output logic [CHANNELS-1:0]      res_valid,
    output logic [32*CHANNELS-1:0]   res_data,
    output logic                     flush,
    output logic [31:0]              flush_pc,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [31:0]              upd_pc,
    output logic [31:0]              upd_target,
    output logic                     upd_taken,
    output logic                     upd_mispred,
    output logic [CNT_W-1:0]         upd_drop_cnt
);

    // Branch op encodings; these mirror the ALU_* codes shared with decode.
    localparam logic [7:0] ALU_BEQ  = 8'h50;
    localparam logic [7:0] ALU_BNE  = 8'h51;
    localparam logic [7:0] ALU_BLT  = 8'h52;
    localparam logic [7:0] ALU_BGE  = 8'h53;
    localparam logic [7:0] ALU_BLTU = 8'h54;
    localparam logic [7:0] ALU_BGEU = 8'h55;
    localparam logic [7:0] ALU_B    = 8'h56;
    localparam logic [7:0] ALU_BL   = 8'h57;
    localparam logic [7:0] ALU_JIRL = 8'h58;

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int OCC_W = $clog2(UPD_DEPTH) + 1;
    localparam int NUM_W = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_W + 1;

    // ------------------------------------------------------------------
    // Per-lane resolution
    // ------------------------------------------------------------------
    logic [31:0]         lane_pc     [CHANNELS];
    logic [31:0]         lane_pc4    [CHANNELS];
    logic [31:0]         lane_r1     [CHANNELS];
    logic [31:0]         lane_r2     [CHANNELS];
    logic [31:0]         lane_off16  [CHANNELS];
    logic [31:0]         lane_off26  [CHANNELS];
    logic [31:0]         lane_tgt    [CHANNELS];
    logic [31:0]         lane_nxt    [CHANNELS];
    logic [CHANNELS-1:0] lane_br;
    logic [CHANNELS-1:0] lane_static;
    logic [CHANNELS-1:0] lane_taken;
    logic [CHANNELS-1:0] lane_mis;
    logic                unused_inst;

    // Decode each lane, evaluate the condition and compute target / next pc.
    always_comb begin
        lane_br     = '0;
        lane_static = '0;
        lane_taken  = '0;
        lane_mis    = '0;
        unused_inst = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            lane_pc[i]    = in_pc[32*i +: 32];
            lane_r1[i]    = in_reg1[32*i +: 32];
            lane_r2[i]    = in_reg2[32*i +: 32];
            lane_pc4[i]   = lane_pc[i] + 32'd4;
            lane_off16[i] = {{14{in_inst[32*i+25]}}, in_inst[32*i+10 +: 16], 2'b00};
            lane_off26[i] = {{4{in_inst[32*i+9]}}, in_inst[32*i +: 10],
                             in_inst[32*i+10 +: 16], 2'b00};
            lane_tgt[i]   = lane_pc[i] + lane_off16[i];
            unused_inst   = unused_inst ^ (^in_inst[32*i+26 +: 6]);

            lane_br[i] = 1'b1;
            case (in_aluop[8*i +: 8])
                ALU_BEQ:  lane_taken[i] = (lane_r1[i] == lane_r2[i]);
                ALU_BNE:  lane_taken[i] = (lane_r1[i] != lane_r2[i]);
                ALU_BLT:  lane_taken[i] = ($signed(lane_r1[i]) <  $signed(lane_r2[i]));
                ALU_BGE:  lane_taken[i] = ($signed(lane_r1[i]) >= $signed(lane_r2[i]));
                ALU_BLTU: lane_taken[i] = (lane_r1[i] <  lane_r2[i]);
                ALU_BGEU: lane_taken[i] = (lane_r1[i] >= lane_r2[i]);
                ALU_B, ALU_BL: begin
                    lane_taken[i]  = 1'b1;
                    lane_static[i] = 1'b1;
                    lane_tgt[i]    = lane_pc[i] + lane_off26[i];
                end
                ALU_JIRL: begin
                    lane_taken[i] = 1'b1;
                    lane_tgt[i]   = lane_r1[i] + lane_off16[i];
                end
                default: begin
                    lane_br[i]  = 1'b0;
                    lane_tgt[i] = lane_pc4[i];
                end
            endcase

            lane_nxt[i] = lane_taken[i] ? lane_tgt[i] : lane_pc4[i];

            // A non-branch predicted taken sent fetch down a bogus path; it
            // redirects to its own fall-through.
            if (lane_br[i])
                lane_mis[i] = (lane_taken[i] != in_pre_taken[i]) ||
                              (lane_taken[i] && (in_pre_addr[32*i +: 32] != lane_tgt[i]));
            else
                lane_mis[i] = in_pre_taken[i];
        end
    end

    // ------------------------------------------------------------------
    // Prioritisation: oldest mispredicting lane wins, younger lanes die
    // ------------------------------------------------------------------
    logic                flush_r;
    logic [31:0]         flush_pc_r;
    logic [CHANNELS-1:0] res_valid_r;
    logic [32*CHANNELS-1:0] res_data_r;

    logic                kill;
    logic                win;
    logic [31:0]         win_pc;
    logic [CHANNELS-1:0] survive;
    logic [CHANNELS-1:0] push_req;

    // Walk lanes oldest-first; the cycle after a redirect everything is wrong-path.
    always_comb begin
        kill     = flush_r | ext_flush;
        win      = 1'b0;
        win_pc   = '0;
        survive  = '0;
        push_req = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_valid[i] && !kill && !win) begin
                survive[i]  = 1'b1;
                push_req[i] = lane_br[i] & ~lane_static[i];
                if (lane_mis[i]) begin
                    win    = 1'b1;
                    win_pc = lane_nxt[i];
                end
            end
        end
    end

    // Result / redirect pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= '0;
            res_data_r  <= '0;
            flush_r     <= 1'b0;
            flush_pc_r  <= '0;
        end else begin
            res_valid_r <= survive;
            flush_r     <= win;
            flush_pc_r  <= win ? win_pc : 32'd0;
            for (int i = 0; i < CHANNELS; i++)
                res_data_r[32*i +: 32] <= survive[i] ? lane_pc4[i] : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Predictor update FIFO
    // ------------------------------------------------------------------
    logic [31:0]          mem_pc  [UPD_DEPTH];
    logic [31:0]          mem_tgt [UPD_DEPTH];
    logic [UPD_DEPTH-1:0] mem_tk;
    logic [UPD_DEPTH-1:0] mem_mis;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [OCC_W-1:0]     occ;
    logic [CNT_W-1:0]     drop_cnt_r;

    logic                 pop;
    int                   free_slots;
    int                   n_acc;
    int                   n_drop;
    logic [NUM_W-1:0]     acc_num;
    logic [NUM_W-1:0]     drop_num;
    logic [CHANNELS-1:0]  push_en;
    logic [PTR_W-1:0]     push_slot [CHANNELS];
    logic [SUM_W-1:0]     drop_sum;

    // Allocate slots to requesting lanes in age order; a same-cycle pop
    // donates its slot, and whatever does not fit is dropped youngest-first.
    always_comb begin
        pop        = upd_valid & upd_ready;
        free_slots = UPD_DEPTH - int'(occ) + int'(pop);
        n_acc      = 0;
        n_drop     = 0;
        push_en    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            push_slot[i] = '0;
            if (push_req[i]) begin
                if (n_acc < free_slots) begin
                    push_en[i]   = 1'b1;
                    push_slot[i] = tail + PTR_W'(n_acc);
                    n_acc        = n_acc + 1;
                end else begin
                    n_drop = n_drop + 1;
                end
            end
        end
        acc_num  = NUM_W'(n_acc);
        drop_num = NUM_W'(n_drop);
        drop_sum = {1'b0, drop_cnt_r} + SUM_W'(drop_num);
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at UPD_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + PTR_W'(pop);
            tail <= tail + PTR_W'(acc_num);
            occ  <= occ - OCC_W'(pop) + OCC_W'(acc_num);
        end
    end

    // Saturating count of training records lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_r <= '0;
        else if (drop_sum[CNT_W])
            drop_cnt_r <= '1;
        else
            drop_cnt_r <= drop_sum[CNT_W-1:0];
    end

    // Entry storage; no reset needed because the read side is gated by occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push_en[i]) begin
                    mem_pc[push_slot[i]]  <= lane_pc[i];
                    mem_tgt[push_slot[i]] <= lane_tgt[i];
                    mem_tk[push_slot[i]]  <= lane_taken[i];
                    mem_mis[push_slot[i]] <= lane_mis[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; a commit-side flush overrides anything already registered.
    // ------------------------------------------------------------------
    assign res_valid    = res_valid_r & ~{CHANNELS{ext_flush}};
    assign res_data     = res_data_r;
    assign flush        = flush_r & ~ext_flush;
    assign flush_pc     = flush_pc_r;
    assign upd_valid    = (occ != '0);
    assign upd_pc       = upd_valid ? mem_pc[head]  : 32'd0;
    assign upd_target   = upd_valid ? mem_tgt[head] : 32'd0;
    assign upd_taken    = upd_valid & mem_tk[head];
    assign upd_mispred  = upd_valid & mem_mis[head];
    assign upd_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, hand
// sequences for FIFO overflow / ext_flush / reset, and random stimulus against
// a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    localparam logic [7:0] ADD  = 8'h01;
    localparam logic [7:0] BEQ  = 8'h50;
    localparam logic [7:0] BNE  = 8'h51;
    localparam logic [7:0] BLT  = 8'h52;
    localparam logic [7:0] BGE  = 8'h53;
    localparam logic [7:0] BLTU = 8'h54;
    localparam logic [7:0] BGEU = 8'h55;
    localparam logic [7:0] B    = 8'h56;
    localparam logic [7:0] BL   = 8'h57;
    localparam logic [7:0] JIRL = 8'h58;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   in_valid;
    logic [32*CH-1:0] in_pc, in_inst, in_reg1, in_reg2, in_pre_addr;
    logic [8*CH-1:0] in_aluop;
    logic [CH-1:0]   in_pre_taken;
    logic            ext_flush;
    logic [CH-1:0]   res_valid;
    logic [32*CH-1:0] res_data;
    logic            flush;
    logic [31:0]     flush_pc;
    logic            upd_valid, upd_ready;
    logic [31:0]     upd_pc, upd_target;
    logic            upd_taken, upd_mispred;
    logic [CW-1:0]   upd_drop_cnt;

    branch_resolve_unit #(.CHANNELS(CH), .UPD_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_aluop(in_aluop), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr), .ext_flush(ext_flush),
        .res_valid(res_valid), .res_data(res_data), .flush(flush), .flush_pc(flush_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .upd_drop_cnt(upd_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mchk_en = 0;

    // ---------------- reference model state ----------------
    typedef struct { logic [31:0] pc; logic [31:0] tgt; bit tk; bit mis; } ent_t;
    ent_t        q[$];
    bit [CH-1:0] m_rv;
    logic [31:0] m_rd [CH];
    bit          m_fl;
    logic [31:0] m_fpc;
    logic [CW-1:0] m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void resolve(input logic [7:0] op, input logic [31:0] pc,
                                    input logic [31:0] inst, input logic [31:0] r1,
                                    input logic [31:0] r2, output bit is_br,
                                    output bit stat, output bit tk, output logic [31:0] tgt);
        logic signed [17:0] s18;
        logic signed [27:0] s28;
        int o16, o26;
        s18 = {inst[25:10], 2'b00};
        s28 = {inst[9:0], inst[25:10], 2'b00};
        o16 = int'(s18);
        o26 = int'(s28);
        is_br = 1; stat = 0; tk = 0;
        tgt = pc + 32'(o16);
        case (op)
            BEQ:  tk = (r1 == r2);
            BNE:  tk = (r1 != r2);
            BLT:  tk = (int'(r1) <  int'(r2));
            BGE:  tk = (int'(r1) >= int'(r2));
            BLTU: tk = (r1 <  r2);
            BGEU: tk = (r1 >= r2);
            B, BL: begin tk = 1; stat = 1; tgt = pc + 32'(o26); end
            JIRL: begin tk = 1; tgt = r1 + 32'(o16); end
            default: begin is_br = 0; tgt = pc + 32'd4; end
        endcase
    endfunction

    task automatic model_check();
        bit efl;
        if (!mchk_en) return;
        chk("res_valid", 32'(res_valid), ext_flush ? 32'd0 : 32'(m_rv));
        for (int i = 0; i < CH; i++)
            if (m_rv[i] && !ext_flush) chk("res_data", res_data[32*i +: 32], m_rd[i]);
        efl = m_fl && !ext_flush;
        chk("flush", 32'(flush), 32'(efl));
        if (efl) chk("flush_pc", flush_pc, m_fpc);
        chk("upd_valid", 32'(upd_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("upd_pc", upd_pc, q[0].pc);
            chk("upd_target", upd_target, q[0].tgt);
            chk("upd_taken", 32'(upd_taken), 32'(q[0].tk));
            chk("upd_mispred", 32'(upd_mispred), 32'(q[0].mis));
        end
        chk("upd_drop_cnt", 32'(upd_drop_cnt), 32'(m_drop));
    endtask

    task automatic model_step();
        bit kill, br, st, tk, mis;
        logic [31:0] pc, tgt, nxt;
        if (rst) begin
            m_rv = '0; m_fl = 0; m_fpc = '0; m_drop = '0;
            for (int i = 0; i < CH; i++) m_rd[i] = '0;
            q.delete();
            return;
        end
        if (upd_ready && q.size() > 0) q.delete(0);
        kill  = m_fl || ext_flush;
        m_rv  = '0;
        m_fl  = 0;
        m_fpc = '0;
        if (!kill) begin
            for (int i = 0; i < CH; i++) begin
                if (in_valid[i] !== 1'b1) continue;
                pc = in_pc[32*i +: 32];
                resolve(in_aluop[8*i +: 8], pc, in_inst[32*i +: 32], in_reg1[32*i +: 32],
                        in_reg2[32*i +: 32], br, st, tk, tgt);
                nxt = tk ? tgt : pc + 32'd4;
                if (br) mis = (tk != in_pre_taken[i]) || (tk && in_pre_addr[32*i +: 32] != tgt);
                else    mis = in_pre_taken[i];
                m_rv[i] = 1;
                m_rd[i] = pc + 32'd4;
                if (br && !st) begin
                    if (q.size() < DEPTH) q.push_back('{pc, tgt, tk, mis});
                    else if (m_drop != '1) m_drop = m_drop + 1'b1;
                end
                if (mis) begin m_fl = 1; m_fpc = nxt; break; end
            end
        end
    endtask

    // One clock: check this cycle's outputs, then advance DUT and model together.
    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input int off, input bit wide);
        logic [31:0] o, ins;
        o = off;
        ins = 32'h5800_0000;
        ins[25:10] = o[17:2];
        if (wide) ins[9:0] = o[27:18];
        return ins;
    endfunction

    task automatic set_lane(input int i, input bit v, input logic [7:0] op, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                            input bit pt, input logic [31:0] pa);
        in_valid[i]           = v;
        in_aluop[8*i +: 8]    = op;
        in_pc[32*i +: 32]     = pc;
        in_inst[32*i +: 32]   = ins;
        in_reg1[32*i +: 32]   = a;
        in_reg2[32*i +: 32]   = b;
        in_pre_taken[i]       = pt;
        in_pre_addr[32*i +: 32] = pa;
    endtask

    task automatic idle();
        in_valid  = '0;
        ext_flush = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v0; bit v1; logic [7:0] op0; logic [7:0] op1; logic [31:0] pc0;
        int off0; int off1; logic [31:0] a0; logic [31:0] b0; logic [31:0] a1; logic [31:0] b1;
        bit pt0; bit pt1; logic [31:0] pa0; logic [31:0] pa1;
        bit e_fl; logic [31:0] e_fpc; logic [1:0] e_rv; int e_push; bit e_tk; bit e_mis;
        logic [31:0] e_tgt;
    } vec_t;
    vec_t vt [10];
    logic [7:0] ops [11];

    initial begin
        int n;
        // v0 v1 op0 op1 pc0 off0 off1 a0 b0 a1 b1 pt0 pt1 pa0 pa1 | fl fpc rv push tk mis tgt
        vt[0] = '{1,0, BEQ, BNE, 32'h1C000000, 'h10, 0, 5, 5, 0, 0, 1, 0, 32'h1C000010, 0,
                  0, 0, 2'b01, 1, 1, 0, 32'h1C000010};
        vt[1] = '{1,1, BLT, BLTU, 32'h1C000100, 'h20, 'h40, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0,
                  1, 32'h1C000120, 2'b01, 1, 1, 1, 32'h1C000120};
        vt[2] = '{1,1, ADD, BEQ, 32'h100, 0, 8, 0, 0, 7, 7, 1, 0, 0, 0,
                  1, 32'h104, 2'b01, 0, 0, 0, 0};
        vt[3] = '{1,0, JIRL, BEQ, 32'h3000, -4, 0, 32'h2000, 0, 0, 0, 1, 0, 32'h1FF8, 0,
                  1, 32'h1FFC, 2'b01, 1, 1, 1, 32'h1FFC};
        vt[4] = '{1,1, BGEU, BL, 32'h2000, -8, 'h1000, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 32'h3004,
                  0, 0, 2'b11, 1, 0, 0, 32'h1FF8};
        vt[5] = '{1,1, BNE, BGE, 32'h4000, 'h10, 'h10, 3, 3, 5, 1, 1, 1, 32'h4010, 32'h4014,
                  1, 32'h4004, 2'b01, 1, 0, 1, 32'h4010};
        vt[6] = '{1,0, BGE, BEQ, 32'h5000, 'h20, 0, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 1, 0, 32'h5010, 0,
                  1, 32'h5020, 2'b01, 1, 1, 1, 32'h5020};
        vt[7] = '{1,1, ADD, B, 32'h6000, 0, -'h100, 0, 0, 0, 0, 0, 1, 0, 32'h5F04,
                  0, 0, 2'b11, 0, 0, 0, 0};
        vt[8] = '{1,1, ADD, BEQ, 32'h7000, 0, 'h10, 0, 0, 1, 2, 0, 1, 0, 32'h7014,
                  1, 32'h7008, 2'b11, 1, 0, 1, 32'h7014};
        vt[9] = '{1,1, BLTU, BLT, 32'h8000, 'h30, 'h8, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 0, 32'h8030, 0,
                  0, 0, 2'b11, 2, 1, 0, 32'h8030};
        ops = '{ADD, 8'h00, BEQ, BNE, BLT, BGE, BLTU, BGEU, B, BL, JIRL};

        // ---------------- reset ----------------
        rst = 1; ext_flush = 0; upd_ready = 0;
        in_valid = '0; in_pc = '0; in_inst = '0; in_aluop = '0;
        in_reg1 = '0; in_reg2 = '0; in_pre_taken = '0; in_pre_addr = '0;
        cyc();
        cyc();
        rst = 0;
        chk("rst res_valid", 32'(res_valid), 0);
        chk("rst res_data", res_data[31:0], 0);
        chk("rst flush", 32'(flush), 0);
        chk("rst flush_pc", flush_pc, 0);
        chk("rst upd_valid", 32'(upd_valid), 0);
        chk("rst upd_pc", upd_pc, 0);
        chk("rst upd_target", upd_target, 0);
        chk("rst upd_taken", 32'({upd_taken, upd_mispred}), 0);
        chk("rst drop_cnt", 32'(upd_drop_cnt), 0);
        mchk_en = 1;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 10; v++) begin
            upd_ready = 0;
            ext_flush = 0;
            set_lane(0, vt[v].v0, vt[v].op0, vt[v].pc0,
                     mk_inst(vt[v].off0, vt[v].op0 == B || vt[v].op0 == BL),
                     vt[v].a0, vt[v].b0, vt[v].pt0, vt[v].pa0);
            set_lane(1, vt[v].v1, vt[v].op1, vt[v].pc0 + 32'd4,
                     mk_inst(vt[v].off1, vt[v].op1 == B || vt[v].op1 == BL),
                     vt[v].a1, vt[v].b1, vt[v].pt1, vt[v].pa1);
            cyc();
            idle();
            chk($sformatf("v%0d flush", v), 32'(flush), 32'(vt[v].e_fl));
            if (vt[v].e_fl) chk($sformatf("v%0d flush_pc", v), flush_pc, vt[v].e_fpc);
            chk($sformatf("v%0d res_valid", v), 32'(res_valid), 32'(vt[v].e_rv));
            chk($sformatf("v%0d res_data0", v), res_data[31:0], vt[v].pc0 + 32'd4);
            chk($sformatf("v%0d upd_valid", v), 32'(upd_valid), 32'(vt[v].e_push > 0));
            if (vt[v].e_push > 0) begin
                chk($sformatf("v%0d upd_taken", v), 32'(upd_taken), 32'(vt[v].e_tk));
                chk($sformatf("v%0d upd_mispred", v), 32'(upd_mispred), 32'(vt[v].e_mis));
                chk($sformatf("v%0d upd_target", v), upd_target, vt[v].e_tgt);
            end
            upd_ready = 1;
            n = 0;
            for (int k = 0; k < 6; k++) begin
                if (upd_valid) n++;
                cyc();
            end
            chk($sformatf("v%0d push_count", v), 32'(n), 32'(vt[v].e_push));
        end

        // ---------------- FIFO overflow and ordered drain ----------------
        upd_ready = 0;
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 1, BNE, 32'h9000 + 32'(8*c), mk_inst('h10, 0), 4, 4, 0, 0);
            set_lane(1, 1, BNE, 32'h9004 + 32'(8*c), mk_inst('h10, 0), 4, 4, 0, 0);
            cyc();
        end
        idle();
        chk("full drop_cnt", 32'(upd_drop_cnt), 2);
        chk("full head pc", upd_pc, 32'h9000);
        cyc();
        chk("stall head pc", upd_pc, 32'h9000);
        upd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d pc", k), upd_pc, 32'h9000 + 32'(4*k));
            cyc();
        end
        chk("drained upd_valid", 32'(upd_valid), 0);
        upd_ready = 0;

        // ---------------- ext_flush interactions ----------------
        set_lane(0, 1, ADD, 32'hA000, 32'h0, 0, 0, 1, 0);
        set_lane(1, 0, ADD, 32'hA004, 32'h0, 0, 0, 0, 0);
        ext_flush = 1;
        cyc();
        idle();
        chk("xf same-cycle flush", 32'(flush), 0);
        chk("xf same-cycle res_valid", 32'(res_valid), 0);
        chk("xf same-cycle no push", 32'(upd_valid), 0);
        set_lane(0, 1, BEQ, 32'hA100, mk_inst('h10, 0), 1, 2, 1, 32'hA110);
        cyc();
        idle();
        ext_flush = 1;
        #1;
        chk("xf mask flush", 32'(flush), 0);
        chk("xf mask res_valid", 32'(res_valid), 0);
        chk("xf fifo kept", upd_pc, 32'hA100);
        cyc();
        ext_flush = 0;

        // ---------------- reset with a busy FIFO ----------------
        set_lane(0, 1, BNE, 32'hB000, mk_inst('h10, 0), 1, 2, 1, 32'hB010);
        set_lane(1, 1, BNE, 32'hB004, mk_inst('h10, 0), 1, 2, 1, 32'hB014);
        cyc();
        idle();
        chk("pre-rst upd_valid", 32'(upd_valid), 1);
        rst = 1;
        cyc();
        rst = 0;
        chk("mid-rst upd_valid", 32'(upd_valid), 0);
        chk("mid-rst drop_cnt", 32'(upd_drop_cnt), 0);

        // ---------------- random stimulus vs model ----------------
        for (int r = 0; r < 600; r++) begin
            rst       = ($urandom_range(0, 99) == 0);
            ext_flush = ($urandom_range(0, 15) == 0);
            upd_ready = $urandom_range(0, 1);
            for (int i = 0; i < CH; i++) begin
                logic [7:0]  op;
                logic [31:0] pc, ins, a, b, tg;
                bit br, st, tk, pt;
                op  = ops[$urandom_range(0, 10)];
                pc  = $urandom & 32'hFFFF_FFFC;
                ins = $urandom;
                a   = $urandom;
                b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
                resolve(op, pc, ins, a, b, br, st, tk, tg);
                pt  = ($urandom_range(0, 3) == 0) ? !tk : tk;
                set_lane(i, $urandom_range(0, 3) != 0, op, pc, ins, a, b, pt,
                         ($urandom_range(0, 3) == 0) ? $urandom : tg);
            end
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
